// File: rtl/frac_reduce.sv
// Fraction reducer: divides num and den by g in parallel with restoring
// shift-subtract division, one quotient bit per cycle, and flags a zero or non-dividing g.
module frac_reduce #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  input  logic [WIDTH-1:0] g,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] num_q,
  output logic [WIDTH-1:0] den_q,
  output logic             err,
  output logic             inexact,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start is sampled only while busy=0 (IDLE or DONE); valid stays
  // high with stable results until the next accepted start clears it.
  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  gl;
  logic [WIDTH-1:0]  qn, qd;
  logic [WIDTH:0]    rn, rd;
  logic              accept, last;

  logic [WIDTH:0]    rn_sh, rd_sh, rn_nx, rd_nx;
  logic              ge_n, ge_d;
  logic [WIDTH-1:0]  qn_nx, qd_nx;

  assign accept = start && (state != DIV);
  assign last   = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (accept) state_nx = (g == '0) ? DONE : DIV;
      DIV:        if (last)   state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // Output logic decoded from state
  always_comb begin
    busy      = (state == DIV);
    state_dbg = state;
  end

  // One restoring step per operand; R stays below g, so R' fits in WIDTH+1 bits.
  always_comb begin
    rn_sh = {rn[WIDTH-1:0], qn[WIDTH-1]};
    rd_sh = {rd[WIDTH-1:0], qd[WIDTH-1]};
    ge_n  = (rn_sh >= {1'b0, gl});
    ge_d  = (rd_sh >= {1'b0, gl});
    rn_nx = ge_n ? (rn_sh - {1'b0, gl}) : rn_sh;
    rd_nx = ge_d ? (rd_sh - {1'b0, gl}) : rd_sh;
    qn_nx = {qn[WIDTH-2:0], ge_n};
    qd_nx = {qd[WIDTH-2:0], ge_d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      gl      <= '0;
      qn      <= '0;
      qd      <= '0;
      rn      <= '0;
      rd      <= '0;
      num_q   <= '0;
      den_q   <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
      inexact <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      gl      <= g;
      qn      <= num;
      qd      <= den;
      rn      <= '0;
      rd      <= '0;
      inexact <= 1'b0;
      // A zero divisor completes immediately with forced-zero quotients.
      valid   <= (g == '0);
      err     <= (g == '0);
      if (g == '0) begin
        num_q <= '0;
        den_q <= '0;
      end
    end else if (state == DIV) begin
      cnt <= cnt + CW'(1);
      qn  <= qn_nx;
      qd  <= qd_nx;
      rn  <= rn_nx;
      rd  <= rd_nx;
      if (last) begin
        num_q   <= qn_nx;
        den_q   <= qd_nx;
        inexact <= (rn_nx != '0) || (rd_nx != '0);
        valid   <= 1'b1;
      end
    end
  end

endmodule
